// File: rtl/unpadding.sv
// Strips a PADDING-wide border from a raster-order square frame of P*P pixels,
// emitting the SIZE*SIZE interior pixels with one cycle of latency.
module unpadding #(
  parameter int N       = 8,
  parameter int CHANNEL = 3,
  parameter int SIZE    = 32,
  parameter int PADDING = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 input_vld,
  input  logic [CHANNEL*N-1:0] input_din,
  output logic [CHANNEL*N-1:0] unpadding_dout,
  output logic                 unpadding_dout_vld,
  output logic                 unpadding_dout_end
);

  localparam int P  = SIZE + 2 * PADDING;
  localparam int CW = (P > 1) ? $clog2(P) : 1;
  localparam int OW = (SIZE * SIZE > 0) ? $clog2(SIZE * SIZE + 1) : 1;

  localparam logic [CW-1:0] LAST   = CW'(P - 1);
  localparam logic [CW:0]   PAD_X  = (CW + 1)'(PADDING);
  localparam logic [CW:0]   SIZE_X = (CW + 1)'(SIZE);
  localparam logic [OW-1:0] FULL   = OW'(SIZE * SIZE);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   col, col_next;
  logic [CW-1:0]   row, row_next;
  logic [OW-1:0]   ocnt, ocnt_next, ocnt_inc;
  logic [CW:0]     col_off, row_off;
  logic            interior, last_col, last_px, emit;

  // Offsetting by PADDING in one extra bit turns the two-sided range check into
  // a single unsigned compare: anything left of the border wraps to a large value.
  assign col_off  = {1'b0, col} - PAD_X;
  assign row_off  = {1'b0, row} - PAD_X;
  assign interior = (col_off < SIZE_X) && (row_off < SIZE_X);
  assign last_col = (col == LAST);
  assign last_px  = last_col && (row == LAST);
  assign ocnt_inc = ocnt + OW'(emit);

  always_comb begin
    state_next = state;
    col_next   = col;
    row_next   = row;
    ocnt_next  = ocnt;
    emit       = 1'b0;
    if (input_vld) begin
      emit      = interior;
      ocnt_next = ocnt_inc;
      if (last_col) begin
        col_next = '0;
        row_next = row + CW'(1);
      end else begin
        col_next = col + CW'(1);
      end
      if (last_px) begin
        state_next = IDLE;
        row_next   = '0;
        ocnt_next  = '0;
      end else begin
        state_next = RUN;
      end
    end
  end

  // ce low aborts the frame exactly like reset.
  always_ff @(posedge clk) begin
    if (!rst_n || !ce) begin
      state              <= IDLE;
      col                <= '0;
      row                <= '0;
      ocnt               <= '0;
      unpadding_dout     <= '0;
      unpadding_dout_vld <= 1'b0;
    end else begin
      state              <= state_next;
      col                <= col_next;
      row                <= row_next;
      ocnt               <= ocnt_next;
      unpadding_dout_vld <= emit;
      unpadding_dout     <= emit ? input_din : '0;
      if (input_vld && last_px) begin
        assert (ocnt_inc == FULL);
      end
    end
  end

  assign unpadding_dout_end = (state == IDLE);

endmodule

// File: tb/tb_unpadding.sv
// Randomised bench for unpadding: a PADDING=1 and a PADDING=0 instance (SIZE=4)
// checked cycle by cycle against a frame-index reference model.
module tb_unpadding;

  localparam int W = 24;

  logic         clk = 1'b0;
  logic         rst_n, ce, vld1, vld0;
  logic [W-1:0] din1, din0, dout1, dout0;
  logic         ov1, ov0, oe1, oe0;

  int checks = 0;
  int failures = 0;

  // Reference model state per instance (index 0: PADDING=0, index 1: PADDING=1)
  int           mk[2];
  logic         m_vld[2];
  logic [W-1:0] m_dout[2];
  logic         m_end[2];
  int           padv[2] = '{0, 1};

  int exp27[16] = '{7, 8, 9, 10, 13, 14, 15, 16, 19, 20, 21, 22, 25, 26, 27, 28};

  always #5 clk = ~clk;

  unpadding #(.N(8), .CHANNEL(3), .SIZE(4), .PADDING(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .input_vld(vld1), .input_din(din1),
    .unpadding_dout(dout1), .unpadding_dout_vld(ov1), .unpadding_dout_end(oe1)
  );

  unpadding #(.N(8), .CHANNEL(3), .SIZE(4), .PADDING(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .input_vld(vld0), .input_din(din0),
    .unpadding_dout(dout0), .unpadding_dout_vld(ov0), .unpadding_dout_end(oe0)
  );

  // Drive one cycle towards instance d, advance the model, return 1 ns after the edge.
  task automatic step(input logic r, input logic c, input logic v, input logic [W-1:0] din,
                      input int d);
    int p, rr, cc;
    logic ins;
    @(negedge clk);
    rst_n = r;
    ce    = c;
    vld1  = v && (d == 1);
    din1  = din;
    vld0  = v && (d == 0);
    din0  = din;
    @(posedge clk);
    for (int dd = 0; dd < 2; dd++) begin
      p = 4 + 2 * padv[dd];
      if (!r || !c) begin
        mk[dd]     = 0;
        m_vld[dd]  = 1'b0;
        m_dout[dd] = '0;
      end else if (v && dd == d) begin
        rr  = mk[dd] / p;
        cc  = mk[dd] % p;
        ins = (rr >= padv[dd]) && (rr < padv[dd] + 4) && (cc >= padv[dd]) && (cc < padv[dd] + 4);
        m_vld[dd]  = ins;
        m_dout[dd] = ins ? din : '0;
        mk[dd]     = (mk[dd] + 1) % (p * p);
      end else begin
        m_vld[dd]  = 1'b0;
        m_dout[dd] = '0;
      end
      m_end[dd] = (mk[dd] == 0);
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, W'($urandom), i % 2);
      checks++;
      if (ov1 !== 1'b0 || dout1 !== '0 || oe1 !== 1'b1 || ov0 !== 1'b0 || dout0 !== '0 || oe0 !== 1'b1) begin
        failures++;
        $display("FAIL reset: vld1=%b dout1=%0d end1=%b vld0=%b dout0=%0d end0=%b required 0/0/1",
                 ov1, dout1, oe1, ov0, dout0, oe0);
      end
    end
  endtask

  task automatic test_frame();
    int got[$];
    got = {};
    for (int i = 0; i < 36; i++) begin
      step(1'b1, 1'b1, 1'b1, W'(i), 1);
      checks++;
      if (ov1 !== m_vld[1] || dout1 !== m_dout[1] || oe1 !== m_end[1]) begin
        failures++;
        $display("FAIL frame px%0d: vld=%b dout=%0d end=%b required %b/%0d/%b",
                 i, ov1, dout1, oe1, m_vld[1], m_dout[1], m_end[1]);
      end
      if (ov1) got.push_back(int'(dout1));
      if (i == 0) begin
        checks++;
        if (oe1 !== 1'b0) begin failures++; $display("FAIL frame_start_end: end=%b required 0", oe1); end
      end
    end
    checks++;
    if (oe1 !== 1'b1) begin failures++; $display("FAIL frame_done_end: end=%b required 1", oe1); end
    checks++;
    if (got.size() != 16) begin
      failures++;
      $display("FAIL frame_count: strobes=%0d required 16", got.size());
    end else begin
      for (int j = 0; j < 16; j++) begin
        checks++;
        if (got[j] != exp27[j]) begin
          failures++;
          $display("FAIL frame_value%0d: got %0d required %0d", j, got[j], exp27[j]);
        end
      end
    end
  endtask

  task automatic test_gaps();
    int got[$];
    int i;
    got = {};
    i = 0;
    while (i < 36) begin
      logic v;
      v = (i % 2 == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) begin
        for (int g = 0; g < int'($urandom_range(1, 20)); g++) begin
          step(1'b1, 1'b1, 1'b0, W'($urandom), 1);
          checks++;
          if (ov1 !== 1'b0 || dout1 !== '0 || oe1 !== m_end[1]) begin
            failures++;
            $display("FAIL gap_idle: vld=%b dout=%0d end=%b required 0/0/%b", ov1, dout1, oe1, m_end[1]);
          end
        end
      end
      step(1'b1, 1'b1, v, v ? W'(i) : W'($urandom), 1);
      checks++;
      if (ov1 !== m_vld[1] || dout1 !== m_dout[1] || oe1 !== m_end[1]) begin
        failures++;
        $display("FAIL gaps px%0d: vld=%b dout=%0d end=%b required %b/%0d/%b",
                 i, ov1, dout1, oe1, m_vld[1], m_dout[1], m_end[1]);
      end
      if (ov1) got.push_back(int'(dout1));
      if (v) i++;
      step(1'b1, 1'b1, 1'b0, W'($urandom), 1);
      checks++;
      if (ov1 !== 1'b0) begin failures++; $display("FAIL gaps_off: vld=%b required 0", ov1); end
    end
    checks++;
    if (got.size() != 16) begin
      failures++;
      $display("FAIL gaps_count: strobes=%0d required 16", got.size());
    end else begin
      for (int j = 0; j < 16; j++) begin
        checks++;
        if (got[j] != exp27[j]) begin
          failures++;
          $display("FAIL gaps_value%0d: got %0d required %0d", j, got[j], exp27[j]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    n = 0;
    for (int i = 0; i < 72; i++) begin
      int val;
      val = (i < 36) ? i : 100 + (i - 36);
      step(1'b1, 1'b1, 1'b1, W'(val), 1);
      checks++;
      if (ov1 !== m_vld[1] || dout1 !== m_dout[1] || oe1 !== m_end[1]) begin
        failures++;
        $display("FAIL b2b px%0d: vld=%b dout=%0d end=%b required %b/%0d/%b",
                 val, ov1, dout1, oe1, m_vld[1], m_dout[1], m_end[1]);
      end
      if (ov1) n++;
      if (i == 35 || i == 36) begin
        checks++;
        if (oe1 !== (i == 35)) begin
          failures++;
          $display("FAIL b2b_end px%0d: end=%b required %b", val, oe1, i == 35);
        end
      end
      if (i == 43) begin
        checks++;
        if (ov1 !== 1'b1 || dout1 !== W'(107)) begin
          failures++;
          $display("FAIL b2b_first2: vld=%b dout=%0d required 1/107", ov1, dout1);
        end
      end
    end
    checks++;
    if (n != 32) begin failures++; $display("FAIL b2b_count: strobes=%0d required 32", n); end
  endtask

  task automatic test_abort(input bit use_rst, input int cut);
    int n;
    for (int i = 0; i < cut; i++) step(1'b1, 1'b1, 1'b1, W'(i), 1);
    step(use_rst ? 1'b0 : 1'b1, use_rst ? 1'b1 : 1'b0, 1'b1, W'(cut), 1);
    checks++;
    if (ov1 !== 1'b0 || dout1 !== '0 || oe1 !== 1'b1) begin
      failures++;
      $display("FAIL abort%0d_cycle: vld=%b dout=%0d end=%b required 0/0/1", use_rst, ov1, dout1, oe1);
    end
    n = 0;
    for (int i = 0; i < 36; i++) begin
      logic [W-1:0] d;
      d = use_rst ? W'(i) : W'($urandom);
      step(1'b1, 1'b1, 1'b1, d, 1);
      checks++;
      if (ov1 !== m_vld[1] || dout1 !== m_dout[1] || oe1 !== m_end[1]) begin
        failures++;
        $display("FAIL abort%0d px%0d: vld=%b dout=%0d end=%b required %b/%0d/%b",
                 use_rst, i, ov1, dout1, oe1, m_vld[1], m_dout[1], m_end[1]);
      end
      if (ov1) begin
        if (use_rst) begin
          checks++;
          if (dout1 !== W'(exp27[n])) begin
            failures++;
            $display("FAIL abort_rst_value%0d: got %0d required %0d", n, dout1, exp27[n]);
          end
        end
        n++;
      end
    end
    checks++;
    if (n != 16 || oe1 !== 1'b1) begin
      failures++;
      $display("FAIL abort%0d_count: strobes=%0d end=%b required 16/1", use_rst, n, oe1);
    end
  endtask

  task automatic test_pad0();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 1'b1, W'(i), 0);
      checks++;
      if (ov0 !== 1'b1 || dout0 !== W'(i) || oe0 !== (i == 15)) begin
        failures++;
        $display("FAIL pad0 px%0d: vld=%b dout=%0d end=%b required 1/%0d/%b", i, ov0, dout0, oe0, i, i == 15);
      end
    end
    step(1'b1, 1'b1, 1'b0, '0, 0);
    checks++;
    if (ov0 !== 1'b0 || dout0 !== '0 || oe0 !== 1'b1) begin
      failures++;
      $display("FAIL pad0_after: vld=%b dout=%0d end=%b required 0/0/1", ov0, dout0, oe0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      logic c, v;
      int d;
      c = ($urandom_range(0, 150) != 0);
      v = ($urandom_range(0, 3) != 0);
      d = (i < 300) ? 1 : 0;
      step(1'b1, c, v, W'($urandom), d);
      checks++;
      if (ov1 !== m_vld[1] || dout1 !== m_dout[1] || oe1 !== m_end[1] ||
          ov0 !== m_vld[0] || dout0 !== m_dout[0] || oe0 !== m_end[0]) begin
        failures++;
        $display("FAIL random cyc%0d: p1 %b/%0h/%b p0 %b/%0h/%b required p1 %b/%0h/%b p0 %b/%0h/%b",
                 i, ov1, dout1, oe1, ov0, dout0, oe0,
                 m_vld[1], m_dout[1], m_end[1], m_vld[0], m_dout[0], m_end[0]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b1; vld1 = 1'b0; vld0 = 1'b0; din1 = '0; din0 = '0;
    test_reset();
    test_frame();
    test_gaps();
    test_back_to_back();
    test_abort(1'b0, 21);
    test_abort(1'b1, 15);
    test_pad0();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
